// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, instruction field positions and fetch entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam int c_op_msb = 31;
    localparam int c_op_lsb = 26;
    localparam int c_rs_msb = 25;
    localparam int c_rs_lsb = 21;
    localparam int c_rt_msb = 20;
    localparam int c_rt_lsb = 16;
    localparam int c_rd_msb = 15;
    localparam int c_rd_lsb = 11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Register written by an instruction; 0 means no destination.
    function automatic logic [4:0] dest_reg(input logic [31:0] instr);
        logic [5:0] w_op;
        w_op     = instr[c_op_msb:c_op_lsb];
        dest_reg = 5'd0;
        case (w_op)
            OP_RTYPE: dest_reg = instr[c_rd_msb:c_rd_lsb];
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW:
                dest_reg = instr[c_rt_msb:c_rt_lsb];
            default: dest_reg = 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo_2w2r.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo_2w2r
// Description : Circular buffer accepting two entries and releasing one or two per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo_2w2r
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_wr_entry_1,
    input  fetch_entry_t             i_wr_entry_2,
    input  logic                     i_pop_1,
    input  logic                     i_pop_2,
    output fetch_entry_t             o_head_1,
    output logic [31:0]              o_head_2_instr,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic [c_aw:0] w_wr_ptr_1;
    logic [c_aw:0] w_rd_ptr_1;
    logic          w_write;

    assign w_wr_ptr_1     = r_wr_ptr + 1'b1;
    assign w_rd_ptr_1     = r_rd_ptr + 1'b1;
    assign w_write        = i_push && !i_flush;
    assign o_count        = r_wr_ptr - r_rd_ptr;
    assign o_head_1       = r_mem[r_rd_ptr[c_aw-1:0]];
    assign o_head_2_instr = r_mem[w_rd_ptr_1[c_aw-1:0]].instr;

    // Extra pointer bit separates full (msb differs) from empty (equal).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 2'd2;
            if (i_pop_2)      r_rd_ptr <= r_rd_ptr + 2'd2;
            else if (i_pop_1) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{instr: 32'd0, pc: RESET_PC};
            end
        end else if (w_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_wr_ptr[c_aw-1:0] == c_aw'(i))        r_mem[i] <= i_wr_entry_1;
                else if (w_wr_ptr_1[c_aw-1:0] == c_aw'(i)) r_mem[i] <= i_wr_entry_2;
            end
        end
    end

    int w_pop_n;
    assign w_pop_n = i_pop_2 ? 2 : (i_pop_1 ? 1 : 0);

    always @(posedge clk) begin
        if (rst_n && w_write) begin
            assert (int'(o_count) + 2 - w_pop_n <= DEPTH);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_dual.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_dual
// Description : Dual-issue fetch stage and instruction queue with redirect flush.
//               Optional macro DUAL_DEP_CHECK_EN holds slot 2 on a RAW hazard with slot 1.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_dual
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data_1,
    input  logic [31:0] imem_data_2,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic [31:0] instr_1,
    output logic [31:0] pc_4,
    output logic        valid_1,
    output logic [31:0] instr_2,
    output logic [31:0] pc_8,
    output logic        valid_2
);

    localparam int c_cw = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_addr;
    logic          r_inflight;
    logic          r_req_epoch;
    logic          r_epoch;

    logic [c_cw-1:0] w_count;
    logic [c_cw:0]   w_need;
    fetch_entry_t    w_head_1;
    logic [31:0]     w_head_2_instr;
    fetch_entry_t    w_wr_1;
    fetch_entry_t    w_wr_2;
    logic            w_req;
    logic            w_push;
    logic            w_pop_1;
    logic            w_pop_2;
    logic            w_occ_2;
    logic            w_dep;

    // Space for this request plus any response still on its way back.
    assign w_need = {1'b0, w_count} + (r_inflight ? (c_cw+1)'(4) : (c_cw+1)'(2));
    assign w_req  = rst_n && !redirect && (w_need <= (c_cw+1)'(DEPTH));

    assign w_push = imem_valid && r_inflight && (r_req_epoch == r_epoch) && !redirect;
    assign w_wr_1 = '{instr: imem_data_1, pc: r_req_addr};
    assign w_wr_2 = '{instr: imem_data_2, pc: r_req_addr + 32'd4};

`ifdef DUAL_DEP_CHECK_EN
    logic [4:0] w_dest_1;
    assign w_dest_1 = dest_reg(w_head_1.instr);
    assign w_dep    = (w_dest_1 != 5'd0) &&
                      ((w_dest_1 == w_head_2_instr[c_rs_msb:c_rs_lsb]) ||
                       (w_dest_1 == w_head_2_instr[c_rt_msb:c_rt_lsb]));
`else
    assign w_dep = 1'b0;
`endif

    assign valid_1 = (w_count != '0);
    assign w_occ_2 = (w_count >= c_cw'(2));
    assign valid_2 = w_occ_2 && !w_dep;

    assign w_pop_2 = out_ready && valid_2 && !redirect;
    assign w_pop_1 = out_ready && valid_1 && !valid_2 && !redirect;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign instr_1   = valid_1 ? w_head_1.instr : 32'd0;
    assign instr_2   = w_occ_2 ? w_head_2_instr : 32'd0;
    assign pc_4      = w_head_1.pc + 32'd4;
    assign pc_8      = w_head_1.pc + 32'd8;

    fetch_fifo_2w2r #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_flush        (redirect),
        .i_push         (w_push),
        .i_wr_entry_1   (w_wr_1),
        .i_wr_entry_2   (w_wr_2),
        .i_pop_1        (w_pop_1),
        .i_pop_2        (w_pop_2),
        .o_head_1       (w_head_1),
        .o_head_2_instr (w_head_2_instr),
        .o_count        (w_count)
    );

    // Epoch tags each request so a response crossing a redirect is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_inflight  <= 1'b0;
            r_req_epoch <= 1'b0;
            r_epoch     <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_epoch    <= ~r_epoch;
            end else if (w_req) begin
                r_fetch_pc  <= r_fetch_pc + 32'd8;
                r_req_addr  <= r_fetch_pc;
                r_req_epoch <= r_epoch;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_dual.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_dual
// Description : Self-checking bench for fetch_queue_dual (scoreboard + reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_queue_dual;
    import cpu_pkg::*;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data_1 = 32'd0;
    logic [31:0] imem_data_2 = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] instr_1, pc_4, instr_2, pc_8;
    logic        valid_1, valid_2;

    always #5 clk = ~clk;

    fetch_queue_dual #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data_1(imem_data_1), .imem_data_2(imem_data_2),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
        .instr_1(instr_1), .pc_4(pc_4), .valid_1(valid_1),
        .instr_2(instr_2), .pc_8(pc_8), .valid_2(valid_2)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          vis;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    logic [31:0] m_fetch_pc = RESET_PC;
    bit          m_prev_req = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = 32'd0;
    bit          prev_redir = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [5:0]  op;
        if (a == 32'h0000_0200) return 32'h2005_0001;   // addi r5,r0,1
        if (a == 32'h0000_0204) return 32'h00A5_3020;   // add  r6,r5,r5
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 13);
        case (h[1:0])
            2'd0:    op = 6'h00;
            2'd1:    op = 6'h08;
            2'd2:    op = 6'h23;
            default: op = 6'h04;
        endcase
        return {op, 2'b00, h[4:2], 2'b00, h[7:5], 2'b00, h[10:8], h[21:11]};
    endfunction

    // Does the younger instruction b read what the older instruction a writes?
    function automatic bit exp_dep(input logic [31:0] a, input logic [31:0] b);
`ifdef DUAL_DEP_CHECK_EN
        logic [5:0] op;
        logic [4:0] d;
        op = a[31:26];
        if (op == 6'h00) d = a[15:11];
        else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23}) d = a[20:16];
        else d = 5'd0;
        return (d != 5'd0) && (d == b[25:21] || d == b[20:16]);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: compares the DUT against the scoreboard once per cycle.
    initial begin
        int cnt;
        bit e_req, e_v1, e_v2;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                cnt = 0;
                foreach (exp_q[i]) if (exp_q[i].vis <= cyc) cnt++;
                e_req = !redirect && ((DEPTH - cnt) >= (2 + 2 * int'(m_prev_req)));
                chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
                if (e_req) chk("imem_addr", imem_addr, m_fetch_pc);
                if (redirect)   m_fetch_pc = redirect_pc;
                else if (e_req) m_fetch_pc = m_fetch_pc + 32'd8;
                m_prev_req = e_req;
                chk("v2_leads_v1", {31'd0, valid_2 & ~valid_1}, 32'd0);
                if (!redirect) begin
                    e_v1 = (cnt >= 1);
                    e_v2 = (cnt >= 2) && !exp_dep(exp_q[0].instr, exp_q[1].instr);
                    chk("valid_1", {31'd0, valid_1}, {31'd0, e_v1});
                    chk("valid_2", {31'd0, valid_2}, {31'd0, e_v2});
                    if (e_v1) begin
                        chk("instr_1", instr_1, exp_q[0].instr);
                        chk("pc_4", pc_4, exp_q[0].pc + 32'd4);
                    end
                    if (e_v2) begin
                        chk("instr_2", instr_2, exp_q[1].instr);
                        chk("pc_8", pc_8, exp_q[0].pc + 32'd8);
                    end
                    if (out_ready && e_v1) begin
                        void'(exp_q.pop_front());
                        if (e_v2) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Driver: one cycle of stimulus plus the instruction memory response.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (redir) exp_q.delete();
        if (pend) begin
            imem_valid  = 1'b1;
            imem_data_1 = mem_word(pend_addr);
            imem_data_2 = mem_word(pend_addr + 32'd4);
            if (!redir) begin
                exp_q.push_back('{instr: imem_data_1, pc: pend_addr, vis: cyc + 1});
                exp_q.push_back('{instr: imem_data_2, pc: pend_addr + 32'd4, vis: cyc + 1});
            end
        end else begin
            // Unrequested junk right after a redirect must be ignored.
            imem_valid  = prev_redir;
            imem_data_1 = $urandom;
            imem_data_2 = $urandom;
        end
        prev_redir = redir;
        #1;
        pend      = imem_req;
        pend_addr = imem_addr;
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid_1", {31'd0, valid_1}, 32'd0);
        chk("rst_valid_2", {31'd0, valid_2}, 32'd0);
        chk("rst_instr_1", instr_1, 32'd0);
        chk("rst_instr_2", instr_2, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_4", pc_4, RESET_PC + 32'd4);
        chk("rst_pc_8", pc_8, RESET_PC + 32'd8);
    endtask

    // Releases reset at a negedge while a stale response is driven, then
    // checks the first pair arrives in the third cycle.
    task automatic release_reset();
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        imem_valid  = 1'b1;
        imem_data_1 = 32'hDEAD_BEEF;
        imem_data_2 = 32'hBAD0_BAD0;
        exp_q.delete();
        m_fetch_pc  = RESET_PC;
        m_prev_req  = 0;
        prev_redir  = 0;
        mon_en      = 1;
        #1;
        pend      = imem_req;
        pend_addr = imem_addr;
        chk("first_addr", imem_addr, RESET_PC);
        chk("cyc1_valid_1", {31'd0, valid_1}, 32'd0);
        step(1, 0, 32'd0);
        chk("cyc2_valid_1", {31'd0, valid_1}, 32'd0);
        step(1, 0, 32'd0);
        chk("cyc3_valid_1", {31'd0, valid_1}, 32'd1);
        chk("cyc3_valid_2", {31'd0, valid_2}, {31'd0, !exp_dep(mem_word(RESET_PC), mem_word(RESET_PC + 32'd4))});
        chk("cyc3_instr_1", instr_1, mem_word(RESET_PC));
        chk("cyc3_pc_4", pc_4, RESET_PC + 32'd4);
    endtask

    initial begin
        logic [31:0] h_instr, h_pc, e_i1;
        bit          found, e_v2;

        // Power-on reset
        #2;
        check_reset_outputs();
        @(negedge clk);
        release_reset();
        repeat (20) step(1, 0, 32'd0);

        // Backpressure: queue fills, requests stop, outputs hold
        step(0, 0, 32'd0);
        step(0, 0, 32'd0);
        h_instr = instr_1;
        h_pc    = pc_4;
        repeat (8) begin
            step(0, 0, 32'd0);
            chk("hold_instr_1", instr_1, h_instr);
            chk("hold_pc_4", pc_4, h_pc);
        end
        chk("full_req_low", {31'd0, imem_req}, 32'd0);
        chk("full_valid_2", {31'd0, valid_1 & valid_2}, 32'd1);
        repeat (20) step(1, 0, 32'd0);

        // Redirect with a response in flight
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend) found = 1;
            else step(1, 0, 32'd0);
        end
        chk("inflight_found", {31'd0, found}, 32'd1);
        step(1, 1, 32'h0000_0104);
        step(1, 0, 32'd0);
        chk("redir_n1_valid_1", {31'd0, valid_1}, 32'd0);
        step(1, 0, 32'd0);
        chk("redir_n2_valid_1", {31'd0, valid_1}, 32'd0);
        step(1, 0, 32'd0);
        chk("redir_n3_valid_1", {31'd0, valid_1}, 32'd1);
        chk("redir_n3_pc_4", pc_4, 32'h0000_0108);
        chk("redir_n3_instr_1", instr_1, mem_word(32'h0000_0104));
        repeat (10) step(1, 0, 32'd0);

        // Dependent pair: addi r5,r0,1 then add r6,r5,r5
        step(1, 1, 32'h0000_0200);
        repeat (3) step(1, 0, 32'd0);
        e_v2 = !exp_dep(32'h2005_0001, 32'h00A5_3020);
        chk("dep_instr_1", instr_1, 32'h2005_0001);
        chk("dep_valid_2", {31'd0, valid_2}, {31'd0, e_v2});
        e_i1 = e_v2 ? mem_word(32'h0000_0208) : 32'h00A5_3020;
        step(1, 0, 32'd0);
        chk("dep_next_instr_1", instr_1, e_i1);
        repeat (10) step(1, 0, 32'd0);

        // Randomised traffic
        repeat (300) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 {20'd0, 10'($urandom_range(0, 1023)), 2'b00});
        end

        // Asynchronous reset mid-burst
        repeat (5) step(1, 0, 32'd0);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        repeat (150) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 {20'd0, 10'($urandom_range(0, 1023)), 2'b00});
        end
        repeat (5) step(1, 0, 32'd0);

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
